// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with configurable reset value
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input; resets to the line's idle level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with valid/ready delivery
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OS_RATE     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick16,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int             TW         = $clog2(OS_RATE);
  localparam logic [TW-1:0]  HALF_TICK  = TW'(OS_RATE / 2 - 1);
  localparam logic [TW-1:0]  FULL_TICK  = TW'(OS_RATE - 1);
  localparam logic [3:0]     LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0]     LAST_STOP  = 4'(STOP_BITS - 1);
  localparam bit             HAS_PARITY = (PARITY_MODE != PARITY_NONE);
  localparam logic           ODD_BIT    = (PARITY_MODE == PARITY_ODD);

  logic                 w_rxs;
  logic                 w_fall;
  logic                 r_rxs_prev;
  rx_state_t            r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_acc;
  logic                 r_perr_int;
  logic                 r_ferr_int;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rxs)
  );

  // Previous synchronised level, used only to find start-bit falling edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxs_prev <= 1'b1;
    end else begin
      r_rxs_prev <= w_rxs;
    end
  end

  assign w_fall = r_rxs_prev & ~w_rxs;

  // Frame FSM: mid-bit sampling, error tracking and single-cycle delivery
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RX_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_acc  <= 1'b0;
      r_perr_int <= 1'b0;
      r_ferr_int <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_state    <= RX_START;
            busy       <= 1'b1;
            r_tick_cnt <= '0;
            r_par_acc  <= 1'b0;
            r_perr_int <= 1'b0;
            r_ferr_int <= 1'b0;
          end
        end
        RX_START: begin
          if (tick16) begin
            if (r_tick_cnt == HALF_TICK) begin
              // Re-align the tick phase so later samples land mid-bit
              r_tick_cnt <= '0;
              if (!w_rxs) begin
                r_state   <= RX_DATA;
                r_bit_cnt <= '0;
              end else begin
                r_state <= RX_IDLE;
                busy    <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        RX_DATA: begin
          if (tick16) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
            if (r_tick_cnt == FULL_TICK) begin
              r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
              r_par_acc <= r_par_acc ^ w_rxs;
              if (r_bit_cnt == LAST_DATA) begin
                r_bit_cnt <= '0;
                r_state   <= HAS_PARITY ? RX_PARITY : RX_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
        end
        RX_PARITY: begin
          if (tick16) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
            if (r_tick_cnt == FULL_TICK) begin
              r_perr_int <= r_par_acc ^ w_rxs ^ ODD_BIT;
              r_bit_cnt  <= '0;
              r_state    <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (tick16) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
            if (r_tick_cnt == FULL_TICK) begin
              if (!w_rxs) begin
                r_ferr_int <= 1'b1;
              end
              if (r_bit_cnt == LAST_STOP) begin
                // Leave at mid-stop so a back-to-back start edge is not missed
                r_state <= RX_IDLE;
                busy    <= 1'b0;
                if (rx_valid && !rx_ready) begin
                  overrun <= 1'b1;
                end else begin
                  rx_data    <= r_shift;
                  parity_err <= r_perr_int;
                  frame_err  <= r_ferr_int | ~w_rxs;
                  rx_valid   <= 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
        end
        default: begin
          r_state <= RX_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - randomized self-checking bench for uart_rx_os
module tb_uart_rx_os;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       tick_a;
  logic       tick_b;
  logic       rx_line [4];
  logic       ready   [4];
  logic [7:0] dat     [4];
  logic [6:0] dat_d7;
  logic       vld  [4];
  logic       perr [4];
  logic       ferr [4];
  logic       ovr  [4];
  logic       bsy  [4];

  assign dat[3] = {1'b0, dat_d7};

  uart_rx_os #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OS_RATE(16)) u_none (
    .clk(clk), .reset(reset), .tick16(tick_a), .rx(rx_line[0]), .rx_data(dat[0]),
    .rx_valid(vld[0]), .rx_ready(ready[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
    .overrun(ovr[0]), .busy(bsy[0]));

  uart_rx_os #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OS_RATE(16)) u_even (
    .clk(clk), .reset(reset), .tick16(tick_a), .rx(rx_line[1]), .rx_data(dat[1]),
    .rx_valid(vld[1]), .rx_ready(ready[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
    .overrun(ovr[1]), .busy(bsy[1]));

  uart_rx_os #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .OS_RATE(16)) u_odd (
    .clk(clk), .reset(reset), .tick16(tick_a), .rx(rx_line[2]), .rx_data(dat[2]),
    .rx_valid(vld[2]), .rx_ready(ready[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
    .overrun(ovr[2]), .busy(bsy[2]));

  uart_rx_os #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .OS_RATE(16)) u_d7 (
    .clk(clk), .reset(reset), .tick16(tick_b), .rx(rx_line[3]), .rx_data(dat_d7),
    .rx_valid(vld[3]), .rx_ready(ready[3]), .parity_err(perr[3]), .frame_err(ferr[3]),
    .overrun(ovr[3]), .busy(bsy[3]));

  // Per-instance frame format: u0 8N1, u1 8E1, u2 8O1, u3 7N2 with a tick every 5 clks
  function automatic int nb_of(input int u);
    return (u == 3) ? 7 : 8;
  endfunction
  function automatic int pm_of(input int u);
    return (u == 1) ? 1 : ((u == 2) ? 2 : 0);
  endfunction
  function automatic int ns_of(input int u);
    return (u == 3) ? 2 : 1;
  endfunction
  function automatic int bitclk_of(input int u);
    return (u == 3) ? 80 : 16;
  endfunction

  int         errors;
  int         checks;
  int         cyc = 0;
  int         tick_div;
  bit         rand_ready;
  logic [9:0] exp_mem [4][32];
  int         wr_p [4];
  int         rd_p [4];
  int         start_cyc [4];
  int         lat_exp [4];
  int         ovr_lat_exp [4];
  int         ovr_seen [4];
  int         ovr_exp [4];
  logic       vld_prev [4];
  logic       ovr_prev [4];
  logic [9:0] last_word [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one serial frame on instance u; the model predicts the delivered word
  task automatic send_frame(input int u, input logic [7:0] d, input logic pbit,
                            input bit bad_stop, input bit push, input bit keep_low);
    int         nb;
    int         pm;
    int         ns;
    int         bc;
    logic [7:0] dm;
    logic       perr_e;
    nb = nb_of(u);
    pm = pm_of(u);
    ns = ns_of(u);
    bc = bitclk_of(u);
    dm = d & 8'((1 << nb) - 1);
    perr_e = (pm != 0) && ((^dm ^ pbit) != (pm == 2));
    if (push) begin
      exp_mem[u][wr_p[u] % 32] = {bad_stop, perr_e, dm};
      wr_p[u]++;
    end
    start_cyc[u] = cyc;
    rx_line[u] = 1'b0;
    wait_clks(bc);
    for (int i = 0; i < nb; i++) begin
      rx_line[u] = dm[i];
      wait_clks(bc);
    end
    if (pm != 0) begin
      rx_line[u] = pbit;
      wait_clks(bc);
    end
    for (int s = 0; s < ns; s++) begin
      rx_line[u] = !(bad_stop && (s == ns - 1));
      wait_clks(bc);
    end
    rx_line[u] = keep_low ? 1'b0 : 1'b1;
  endtask

  // Compare process: every presented word must match the head of the expected queue
  always @(negedge clk) begin
    if (reset) begin
      for (int u = 0; u < 4; u++) begin
        vld_prev[u] = 1'b0;
        ovr_prev[u] = 1'b0;
      end
    end else begin
      for (int u = 0; u < 4; u++) begin
        if (vld[u]) begin
          last_word[u] = {ferr[u], perr[u], dat[u]};
          if (rd_p[u] == wr_p[u]) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid u%0d: got word %0h, no word expected", u, last_word[u]);
          end else begin
            chk($sformatf("word_u%0d", u), 32'(last_word[u]), 32'(exp_mem[u][rd_p[u] % 32]));
          end
          if (!vld_prev[u] && lat_exp[u] != 0) begin
            chk($sformatf("valid_latency_u%0d", u), 32'(cyc - start_cyc[u]), 32'(lat_exp[u]));
            lat_exp[u] = 0;
          end
          if (ready[u]) rd_p[u]++;
        end
        if (ovr[u]) begin
          ovr_seen[u]++;
          if (ovr_prev[u]) begin
            checks++;
            errors++;
            $display("FAIL overrun_width u%0d: got 2+ clk pulse, expected 1 clk", u);
          end
          if (ovr_lat_exp[u] != 0) begin
            chk($sformatf("overrun_latency_u%0d", u), 32'(cyc - start_cyc[u]), 32'(ovr_lat_exp[u]));
            ovr_lat_exp[u] = 0;
          end
        end
        vld_prev[u] = vld[u];
        ovr_prev[u] = ovr[u];
      end
    end
  end

  // Baud tick sources: tick_a always high, tick_b one clk in every five
  initial begin
    tick_a   = 1'b1;
    tick_b   = 1'b0;
    tick_div = 0;
    forever begin
      @(posedge clk);
      #1;
      tick_div = (tick_div == 4) ? 0 : tick_div + 1;
      tick_b   = (tick_div == 0);
    end
  end

  // Random consumer back-pressure during the randomized section
  initial begin
    rand_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) begin
        for (int u = 0; u < 4; u++) ready[u] = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    for (int u = 0; u < 4; u++) begin
      rx_line[u]     = 1'b1;
      ready[u]       = 1'b1;
      wr_p[u]        = 0;
      rd_p[u]        = 0;
      start_cyc[u]   = 0;
      lat_exp[u]     = 0;
      ovr_lat_exp[u] = 0;
      ovr_seen[u]    = 0;
      ovr_exp[u]     = 0;
      last_word[u]   = '0;
    end
    wait_clks(3);
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("reset_valid_u%0d", u), 32'(vld[u]), 32'd0);
      chk($sformatf("reset_data_u%0d", u), 32'(dat[u]), 32'd0);
      chk($sformatf("reset_perr_u%0d", u), 32'(perr[u]), 32'd0);
      chk($sformatf("reset_ferr_u%0d", u), 32'(ferr[u]), 32'd0);
      chk($sformatf("reset_ovr_u%0d", u), 32'(ovr[u]), 32'd0);
      chk($sformatf("reset_busy_u%0d", u), 32'(bsy[u]), 32'd0);
    end
    reset = 1'b0;
    wait_clks(10);

    // 0xA5 8N1 with exact latency: start drive + 155 clks
    lat_exp[0] = 155;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(20);
    chk("a5_word", 32'(last_word[0]), 32'h0A5);

    // Even and odd parity on 0x03 with both parity-bit values
    send_frame(1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(10);
    chk("even_p0_word", 32'(last_word[1]), 32'h003);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_clks(10);
    chk("even_p1_word", 32'(last_word[1]), 32'h103);
    send_frame(2, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(10);
    chk("odd_p0_word", 32'(last_word[2]), 32'h103);
    send_frame(2, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_clks(10);
    chk("odd_p1_word", 32'(last_word[2]), 32'h003);

    // Low stop bit on 0x55, then line held low: no second frame
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_clks(5);
    chk("break_word", 32'(last_word[0]), 32'h255);
    wait_clks(300);
    chk("break_busy", 32'(bsy[0]), 32'd0);
    rx_line[0] = 1'b1;
    wait_clks(20);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(10);
    chk("after_break_word", 32'(last_word[0]), 32'h05A);

    // Four-tick low glitch must be rejected
    rx_line[0] = 1'b0;
    wait_clks(4);
    rx_line[0] = 1'b1;
    wait_clks(1);
    chk("glitch_busy_high", 32'(bsy[0]), 32'd1);
    wait_clks(20);
    chk("glitch_busy_low", 32'(bsy[0]), 32'd0);

    // Back-to-back 0x11, 0x22 with consumer stalled: second frame is dropped
    ready[0] = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    ovr_exp[0]     = ovr_exp[0] + 1;
    ovr_lat_exp[0] = 155;
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_clks(20);
    chk("overrun_hold_valid", 32'(vld[0]), 32'd1);
    chk("overrun_hold_data", 32'(dat[0]), 32'h11);
    ready[0] = 1'b1;
    wait_clks(20);

    // 7N2 at one tick per 5 clks: reset mid-DATA, then a clean 0x3C
    rx_line[3] = 1'b0;
    wait_clks(80);
    wait_clks(80);
    wait_clks(40);
    chk("d7_busy_mid", 32'(bsy[3]), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(vld[3]), 32'd0);
    chk("midrst_data", 32'(dat[3]), 32'd0);
    chk("midrst_perr", 32'(perr[3]), 32'd0);
    chk("midrst_ferr", 32'(ferr[3]), 32'd0);
    chk("midrst_ovr", 32'(ovr[3]), 32'd0);
    chk("midrst_busy", 32'(bsy[3]), 32'd0);
    rx_line[3] = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(10);
    send_frame(3, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clks(60);
    chk("d7_word", 32'(last_word[3]), 32'h03C);

    // Randomized frames on all formats with random back-pressure
    rand_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      int         u;
      logic [7:0] d;
      logic       pb;
      bit         bs;
      u  = $urandom_range(0, 3);
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      bs = ($urandom_range(0, 3) == 0);
      send_frame(u, d, pb, bs, 1'b1, 1'b0);
      wait_clks($urandom_range(2, 40));
    end
    rand_ready = 1'b0;
    wait_clks(2);
    for (int u = 0; u < 4; u++) ready[u] = 1'b1;
    wait_clks(200);

    for (int u = 0; u < 4; u++) begin
      chk($sformatf("drained_u%0d", u), 32'(rd_p[u]), 32'(wr_p[u]));
      chk($sformatf("overrun_count_u%0d", u), 32'(ovr_seen[u]), 32'(ovr_exp[u]));
      chk($sformatf("latency_seen_u%0d", u), 32'(lat_exp[u] + ovr_lat_exp[u]), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
